// File: rtl/uart_sdram_vga_pkg.sv
// Shared definitions for the UART -> SDRAM -> VGA picture path:
// packer FSM encoding, sync preamble bytes and default frame geometry.
package uart_sdram_vga_pkg;

    typedef enum logic [1:0] {
        ST_SYNC0 = 2'd0,
        ST_SYNC1 = 2'd1,
        ST_IDLE  = 2'd2,
        ST_HALF  = 2'd3
    } pix_state_t;

    localparam logic [7:0] SYNC_BYTE0 = 8'hA5;
    localparam logic [7:0] SYNC_BYTE1 = 8'h5A;

    localparam int unsigned DEF_H_PIXEL = 640;
    localparam int unsigned DEF_V_PIXEL = 480;

endpackage

// File: rtl/uart_pix_pack_if.sv
// Byte-in / pixel-out bus of uart_pix_pack; master drives the UART bytes,
// slave (the packer) drives the pixel strobe, position and status pulses.
interface uart_pix_pack_if #(
    parameter int unsigned CNT_W = 19
);
    logic [7:0]       pi_data;
    logic             pi_flag;
    logic [15:0]      po_data;
    logic             po_flag;
    logic [CNT_W-1:0] pix_cnt;
    logic             frame_end;
    logic             err_timeout;

    modport master (
        output pi_data, pi_flag,
        input  po_data, po_flag, pix_cnt, frame_end, err_timeout
    );

    modport slave (
        input  pi_data, pi_flag,
        output po_data, po_flag, pix_cnt, frame_end, err_timeout
    );
endinterface

// File: rtl/uart_pix_pack_frame_cnt.sv
// Pixel position counter wrapping at TOTAL with a frame_end pulse on the
// wrapping increment; shared by the SDRAM write and VGA read sides.
module pix_frame_cnt
    import uart_sdram_vga_pkg::*;
#(
    parameter int unsigned TOTAL = DEF_H_PIXEL * DEF_V_PIXEL,
    parameter int unsigned CNT_W = 19
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             frame_end
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

    logic at_last;
    assign at_last = (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            frame_end <= 1'b0;
        end else begin
            frame_end <= inc && at_last;
            if (clr)
                cnt <= '0;
            else if (inc)
                cnt <= at_last ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/uart_pix_pack.sv
// Packs UART byte pairs into RGB565 words for the SDRAM write FIFO, with an
// inter-byte timeout; UART_PIX_PACK_SYNC_EN adds an A5/5A stream preamble.
module uart_pix_pack
    import uart_sdram_vga_pkg::*;
#(
    parameter int unsigned H_PIXEL     = DEF_H_PIXEL,
    parameter int unsigned V_PIXEL     = DEF_V_PIXEL,
    parameter bit          HI_FIRST    = 1'b1,
    parameter int unsigned TIMEOUT_CYC = 50000,
    parameter int unsigned CNT_W       = 19
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    uart_pix_pack_if.slave  bus
);
    localparam int unsigned      TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

`ifdef UART_PIX_PACK_SYNC_EN
    localparam pix_state_t RST_STATE = ST_SYNC0;
`else
    localparam pix_state_t RST_STATE = ST_IDLE;
`endif

    pix_state_t       state, state_nxt;
    logic [7:0]       byte_lat;
    logic [TMO_W-1:0] tmo_cnt;
    logic             load, emit, drop, sync_done;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            state <= RST_STATE;
        else
            state <= state_nxt;
    end

    // A second byte landing on the timeout cycle takes priority over the drop.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        emit      = 1'b0;
        drop      = 1'b0;
        sync_done = 1'b0;
        case (state)
`ifdef UART_PIX_PACK_SYNC_EN
            ST_SYNC0: begin
                if (bus.pi_flag && bus.pi_data == SYNC_BYTE0)
                    state_nxt = ST_SYNC1;
            end
            ST_SYNC1: begin
                if (bus.pi_flag) begin
                    if (bus.pi_data == SYNC_BYTE1) begin
                        state_nxt = ST_IDLE;
                        sync_done = 1'b1;
                    end else if (bus.pi_data != SYNC_BYTE0) begin
                        state_nxt = ST_SYNC0;
                    end
                end
            end
`endif
            ST_IDLE: begin
                if (bus.pi_flag) begin
                    load      = 1'b1;
                    state_nxt = ST_HALF;
                end
            end
            ST_HALF: begin
                if (bus.pi_flag) begin
                    emit      = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (tmo_cnt == TMO_LAST) begin
                    drop      = 1'b1;
                    state_nxt = RST_STATE;
                end
            end
            default: state_nxt = RST_STATE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            byte_lat        <= '0;
            tmo_cnt         <= '0;
            bus.po_data     <= '0;
            bus.po_flag     <= 1'b0;
            bus.err_timeout <= 1'b0;
        end else begin
            bus.po_flag     <= emit;
            bus.err_timeout <= drop;
            if (load) begin
                byte_lat <= bus.pi_data;
                tmo_cnt  <= '0;
            end else if (state == ST_HALF) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (drop)
                byte_lat <= '0;
            if (emit)
                bus.po_data <= HI_FIRST ? {byte_lat, bus.pi_data} : {bus.pi_data, byte_lat};
        end
    end

    pix_frame_cnt #(
        .TOTAL (H_PIXEL * V_PIXEL),
        .CNT_W (CNT_W)
    ) u_frame_cnt (
        .clk       (sys_clk),
        .rst_n     (sys_rst_n),
        .inc       (emit),
        .clr       (sync_done),
        .cnt       (bus.pix_cnt),
        .frame_end (bus.frame_end)
    );
endmodule

// File: tb/tb_uart_pix_pack.sv
// Directed bench for uart_pix_pack: u0 default geometry, HI_FIRST=1;
// u1 4x2 frame, HI_FIRST=0, 20-cycle timeout. Honours UART_PIX_PACK_SYNC_EN.
module tb_uart_pix_pack;

    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    always #5 sys_clk = ~sys_clk;

    uart_pix_pack_if #(.CNT_W(19)) m0 ();
    uart_pix_pack_if #(.CNT_W(3))  m1 ();

    uart_pix_pack #(
        .H_PIXEL(640), .V_PIXEL(480), .HI_FIRST(1'b1),
        .TIMEOUT_CYC(50000), .CNT_W(19)
    ) u0 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(m0)
    );

    uart_pix_pack #(
        .H_PIXEL(4), .V_PIXEL(2), .HI_FIRST(1'b0),
        .TIMEOUT_CYC(20), .CNT_W(3)
    ) u1 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(m1)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int nflag0 = 0, nerr0 = 0, nflag1 = 0, nerr1 = 0;

    // pulse counters, sampled 2 ns after each rising edge
    always begin
        @(posedge sys_clk);
        #2;
        if (m0.po_flag === 1'b1)     nflag0++;
        if (m0.err_timeout === 1'b1) nerr0++;
        if (m1.po_flag === 1'b1)     nflag1++;
        if (m1.err_timeout === 1'b1) nerr1++;
    end

    initial begin
        m0.pi_data = '0; m0.pi_flag = 1'b0;
        m1.pi_data = '0; m1.pi_flag = 1'b0;
    end

    task automatic send0(input logic [7:0] b);
        @(negedge sys_clk);
        m0.pi_data = b; m0.pi_flag = 1'b1;
        @(negedge sys_clk);
        m0.pi_flag = 1'b0;
    endtask

    task automatic send1(input logic [7:0] b);
        @(negedge sys_clk);
        m1.pi_data = b; m1.pi_flag = 1'b1;
        @(negedge sys_clk);
        m1.pi_flag = 1'b0;
    endtask

    task automatic resync0();
`ifdef UART_PIX_PACK_SYNC_EN
        send0(8'hA5); send0(8'h5A);
`endif
    endtask

    task automatic resync1();
`ifdef UART_PIX_PACK_SYNC_EN
        send1(8'hA5); send1(8'h5A);
`endif
    endtask

    task automatic apply_reset();
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        n_cmp++; if (m0.po_data !== 16'h0000) begin n_fail++; $display("FAIL rst u0 po_data: got %h want 0000", m0.po_data); end
        n_cmp++; if (m0.po_flag !== 1'b0) begin n_fail++; $display("FAIL rst u0 po_flag: got %b want 0", m0.po_flag); end
        n_cmp++; if (m0.pix_cnt !== 19'd0) begin n_fail++; $display("FAIL rst u0 pix_cnt: got %0d want 0", m0.pix_cnt); end
        n_cmp++; if (m0.frame_end !== 1'b0) begin n_fail++; $display("FAIL rst u0 frame_end: got %b want 0", m0.frame_end); end
        n_cmp++; if (m0.err_timeout !== 1'b0) begin n_fail++; $display("FAIL rst u0 err_timeout: got %b want 0", m0.err_timeout); end
        n_cmp++; if (m1.po_data !== 16'h0000) begin n_fail++; $display("FAIL rst u1 po_data: got %h want 0000", m1.po_data); end
        n_cmp++; if (m1.pix_cnt !== 3'd0) begin n_fail++; $display("FAIL rst u1 pix_cnt: got %0d want 0", m1.pix_cnt); end
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        resync0();
        resync1();
    endtask

    task automatic test_hi_first();
        send0(8'hF8);
        n_cmp++; if (m0.po_flag !== 1'b0) begin n_fail++; $display("FAIL hi_first early po_flag: got %b want 0", m0.po_flag); end
        send0(8'h00);
        n_cmp++; if (m0.po_flag !== 1'b1) begin n_fail++; $display("FAIL hi_first po_flag: got %b want 1", m0.po_flag); end
        n_cmp++; if (m0.po_data !== 16'hF800) begin n_fail++; $display("FAIL hi_first po_data: got %h want f800", m0.po_data); end
        n_cmp++; if (m0.pix_cnt !== 19'd1) begin n_fail++; $display("FAIL hi_first pix_cnt: got %0d want 1", m0.pix_cnt); end
        n_cmp++; if (m0.frame_end !== 1'b0) begin n_fail++; $display("FAIL hi_first frame_end: got %b want 0", m0.frame_end); end
        @(negedge sys_clk);
        n_cmp++; if (m0.po_flag !== 1'b0) begin n_fail++; $display("FAIL hi_first pulse width: got %b want 0", m0.po_flag); end
        n_cmp++; if (m0.po_data !== 16'hF800) begin n_fail++; $display("FAIL hi_first hold: got %h want f800", m0.po_data); end
    endtask

    task automatic test_lo_first();
        send1(8'h1F);
        send1(8'h07);
        n_cmp++; if (m1.po_flag !== 1'b1) begin n_fail++; $display("FAIL lo_first po_flag: got %b want 1", m1.po_flag); end
        n_cmp++; if (m1.po_data !== 16'h071F) begin n_fail++; $display("FAIL lo_first po_data: got %h want 071f", m1.po_data); end
        n_cmp++; if (m1.pix_cnt !== 3'd1) begin n_fail++; $display("FAIL lo_first pix_cnt: got %0d want 1", m1.pix_cnt); end
    endtask

    task automatic test_timeout();
        int f0, e0;
        logic [18:0] exp_cnt;
        f0 = nflag0; e0 = nerr0;
        send0(8'h12);
        repeat (49999) @(negedge sys_clk);
        n_cmp++; if (m0.err_timeout !== 1'b0) begin n_fail++; $display("FAIL timeout early err: got %b want 0", m0.err_timeout); end
        @(negedge sys_clk);
        n_cmp++; if (m0.err_timeout !== 1'b1) begin n_fail++; $display("FAIL timeout err pulse: got %b want 1", m0.err_timeout); end
        @(negedge sys_clk);
        n_cmp++; if (m0.err_timeout !== 1'b0) begin n_fail++; $display("FAIL timeout err width: got %b want 0", m0.err_timeout); end
        n_cmp++; if (nflag0 - f0 !== 0) begin n_fail++; $display("FAIL timeout no po_flag: got %0d strobes want 0", nflag0 - f0); end
        n_cmp++; if (nerr0 - e0 !== 1) begin n_fail++; $display("FAIL timeout err count: got %0d want 1", nerr0 - e0); end
        n_cmp++; if (m0.pix_cnt !== 19'd1) begin n_fail++; $display("FAIL timeout pix_cnt kept: got %0d want 1", m0.pix_cnt); end
        resync0();
        send0(8'h34);
        send0(8'h56);
`ifdef UART_PIX_PACK_SYNC_EN
        exp_cnt = 19'd1;
`else
        exp_cnt = 19'd2;
`endif
        n_cmp++; if (m0.po_flag !== 1'b1) begin n_fail++; $display("FAIL timeout realign po_flag: got %b want 1", m0.po_flag); end
        n_cmp++; if (m0.po_data !== 16'h3456) begin n_fail++; $display("FAIL timeout realign po_data: got %h want 3456", m0.po_data); end
        n_cmp++; if (m0.pix_cnt !== exp_cnt) begin n_fail++; $display("FAIL timeout realign pix_cnt: got %0d want %0d", m0.pix_cnt, exp_cnt); end
    endtask

    task automatic test_timeout_edge();
        int e1;
        e1 = nerr1;
        send1(8'hAB);
        repeat (18) @(negedge sys_clk);
        send1(8'hCD);
        n_cmp++; if (m1.po_flag !== 1'b1) begin n_fail++; $display("FAIL tmo_edge po_flag: got %b want 1", m1.po_flag); end
        n_cmp++; if (m1.po_data !== 16'hCDAB) begin n_fail++; $display("FAIL tmo_edge po_data: got %h want cdab", m1.po_data); end
        n_cmp++; if (m1.err_timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_edge err: got %b want 0", m1.err_timeout); end
        n_cmp++; if (m1.pix_cnt !== 3'd2) begin n_fail++; $display("FAIL tmo_edge pix_cnt: got %0d want 2", m1.pix_cnt); end
        repeat (30) @(negedge sys_clk);
        n_cmp++; if (nerr1 - e1 !== 0) begin n_fail++; $display("FAIL tmo_edge err count: got %0d want 0", nerr1 - e1); end
    endtask

    task automatic test_reset_mid_pair();
        int f0, e0;
        send0(8'h77);
        send1(8'h77);
        apply_reset();
        f0 = nflag0; e0 = nerr0;
        repeat (60) @(negedge sys_clk);
        n_cmp++; if (nflag0 - f0 !== 0) begin n_fail++; $display("FAIL mid_pair stray po_flag: got %0d want 0", nflag0 - f0); end
        n_cmp++; if (nerr0 - e0 !== 0) begin n_fail++; $display("FAIL mid_pair stray err: got %0d want 0", nerr0 - e0); end
        resync0();
        resync1();
        send0(8'h34);
        n_cmp++; if (m0.po_flag !== 1'b0) begin n_fail++; $display("FAIL mid_pair first byte po_flag: got %b want 0", m0.po_flag); end
        send0(8'h56);
        n_cmp++; if (m0.po_data !== 16'h3456) begin n_fail++; $display("FAIL mid_pair po_data: got %h want 3456", m0.po_data); end
        n_cmp++; if (m0.pix_cnt !== 19'd1) begin n_fail++; $display("FAIL mid_pair pix_cnt: got %0d want 1", m0.pix_cnt); end
    endtask

    task automatic test_frame_wrap();
        logic [7:0]  lo, hi;
        logic [15:0] exp_d;
        logic [2:0]  exp_c;
        logic        exp_fe;
        for (int i = 0; i < 8; i++) begin
            lo = 8'h10 + 8'(i);
            hi = 8'hE0 + 8'(i);
            send1(lo);
            send1(hi);
            exp_d  = {hi, lo};
            exp_c  = 3'((i + 1) % 8);
            exp_fe = (i == 7);
            n_cmp++; if (m1.po_flag !== 1'b1) begin n_fail++; $display("FAIL frame[%0d] po_flag: got %b want 1", i, m1.po_flag); end
            n_cmp++; if (m1.po_data !== exp_d) begin n_fail++; $display("FAIL frame[%0d] po_data: got %h want %h", i, m1.po_data, exp_d); end
            n_cmp++; if (m1.pix_cnt !== exp_c) begin n_fail++; $display("FAIL frame[%0d] pix_cnt: got %0d want %0d", i, m1.pix_cnt, exp_c); end
            n_cmp++; if (m1.frame_end !== exp_fe) begin n_fail++; $display("FAIL frame[%0d] frame_end: got %b want %b", i, m1.frame_end, exp_fe); end
        end
        @(negedge sys_clk);
        n_cmp++; if (m1.frame_end !== 1'b0) begin n_fail++; $display("FAIL frame_end width: got %b want 0", m1.frame_end); end
    endtask

`ifdef UART_PIX_PACK_SYNC_EN
    task automatic test_sync();
        int f0;
        apply_reset();
        f0 = nflag0;
        send0(8'h00);
        send0(8'hA5);
        send0(8'hA5);
        send0(8'h5A);
        send0(8'h11);
        n_cmp++; if (nflag0 - f0 !== 0) begin n_fail++; $display("FAIL sync early strobes: got %0d want 0", nflag0 - f0); end
        send0(8'h22);
        n_cmp++; if (m0.po_flag !== 1'b1) begin n_fail++; $display("FAIL sync po_flag: got %b want 1", m0.po_flag); end
        n_cmp++; if (m0.po_data !== 16'h1122) begin n_fail++; $display("FAIL sync po_data: got %h want 1122", m0.po_data); end
        n_cmp++; if (m0.pix_cnt !== 19'd1) begin n_fail++; $display("FAIL sync pix_cnt: got %0d want 1", m0.pix_cnt); end
        repeat (3) @(negedge sys_clk);
        n_cmp++; if (nflag0 - f0 !== 1) begin n_fail++; $display("FAIL sync strobe count: got %0d want 1", nflag0 - f0); end
    endtask
`endif

    initial begin
        test_reset();
        test_hi_first();
        test_lo_first();
        test_timeout();
        test_timeout_edge();
        test_reset_mid_pair();
        test_frame_wrap();
`ifdef UART_PIX_PACK_SYNC_EN
        test_sync();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
